// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb
// Multi-port register file with a per-register pending-write scoreboard.
// Sits between decode (reads, issue) and write-back (writes, commit).
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   we/waddr/wdata/wclr NWR write ports, packed; higher port index wins on a
//                       shared address; wclr clears the pending bit of waddr
//   re/raddr            NRD read ports, packed
//   rdata/rbusy         combinational read data and pending status with
//                       same-cycle write bypass
//   iss_valid/iss_addr  destination of an issuing instruction -> pending
//   flush               clear every pending bit
//   busy_cnt            registered number of pending registers
module regfile_mp_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int NWR    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*ADDR_W-1:0] waddr,
    input  logic [NWR*DATA_W-1:0] wdata,
    input  logic [NWR-1:0]        wclr,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic                  iss_valid,
    input  logic [ADDR_W-1:0]     iss_addr,
    input  logic                  flush,
    output logic [ADDR_W:0]       busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_d;

    always_comb begin
        regs_d     = regs_q;
        pend_d     = pend_q;
        busy_cnt_d = '0;

        // Ascending port order lets the highest-index port overwrite lower ones.
        for (int k = 0; k < NWR; k++) begin
            if (we[k] && (waddr[k*ADDR_W +: ADDR_W] != '0)) begin
                regs_d[waddr[k*ADDR_W +: ADDR_W]] = wdata[k*DATA_W +: DATA_W];
            end
        end

        // Flush dominates; otherwise an issue is applied after the clears so a
        // new producer wins over a same-cycle write-back to the same register.
        if (flush) begin
            pend_d = '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (we[k] && wclr[k]) begin
                    pend_d[waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
                end
            end
            if (iss_valid) begin
                pend_d[iss_addr] = 1'b1;
            end
        end

        regs_d[0] = '0;
        pend_d[0] = 1'b0;

        if (rst) begin
            regs_d = '{default: '0};
            pend_d = '0;
        end

        for (int r = 0; r < DEPTH; r++) begin
            busy_cnt_d = busy_cnt_d + (ADDR_W+1)'(pend_d[r]);
        end
    end

    always_ff @(posedge clk) begin
        regs_q     <= regs_d;
        pend_q     <= pend_d;
        busy_cnt_q <= busy_cnt_d;
    end

    always_comb begin : read_ports
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        logic              rb;
        rdata = '0;
        rbusy = '0;
        ra    = '0;
        rd    = '0;
        rb    = 1'b0;
        for (int j = 0; j < NRD; j++) begin
            ra = raddr[j*ADDR_W +: ADDR_W];
            rd = '0;
            rb = 1'b0;
            if (!rst && re[j] && (ra != '0)) begin
                rd = regs_q[ra];
                rb = pend_q[ra];
                for (int k = 0; k < NWR; k++) begin
                    if (we[k] && (waddr[k*ADDR_W +: ADDR_W] == ra)) begin
                        rd = wdata[k*DATA_W +: DATA_W];
                        // Any clearing write makes the value available now.
                        if (wclr[k]) begin
                            rb = 1'b0;
                        end
                    end
                end
            end
            rdata[j*DATA_W +: DATA_W] = rd;
            rbusy[j]                  = rb;
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule
